// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a word-addressed, byte-masked memory.
// Splits misaligned accesses into two beats, then merges and extends load data.
module mem_access_unit #(
  parameter int ADDR_W = 8,
  parameter int DWIDTH = 32
) (
  input  logic              m_clk,
  input  logic              m_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              resp_err,
  output logic              m_ce,
  output logic              m_wr_en,
  output logic [3:0]        m_mask,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DWIDTH-1:0] m_store_data,
  input  logic [DWIDTH-1:0] m_load_data
);

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] w_q, w_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [DWIDTH-1:0] lo_q, lo_d;

  logic              rv_q, rv_d;
  logic              err_q, err_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;

  logic              ready_c;
  logic              ce_c;
  logic              wr_c;
  logic [3:0]        mask_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DWIDTH-1:0] sdata_c;

  logic [1:0]          off;
  logic [ADDR_W-1:0]   wa;
  logic [7:0]          wm;
  logic [7:0]          lat_wm;
  logic [5:0]          hi_sh;
  logic [2*DWIDTH-1:0] cat;

  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];

  function automatic logic [3:0] byte_mask(input logic [1:0] sz);
    unique case (sz)
      2'b00:   byte_mask = 4'b0001;
      2'b01:   byte_mask = 4'b0011;
      2'b10:   byte_mask = 4'b1111;
      default: byte_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [DWIDTH-1:0] ext(
    input logic [DWIDTH-1:0] raw,
    input logic [1:0]        sz,
    input logic              uns
  );
    unique case (sz)
      2'b00: ext = uns ? {{(DWIDTH-8){1'b0}}, raw[7:0]}
                       : {{(DWIDTH-8){raw[7]}}, raw[7:0]};
      2'b01: ext = uns ? {{(DWIDTH-16){1'b0}}, raw[15:0]}
                       : {{(DWIDTH-16){raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  endfunction

  assign off    = req_addr[1:0];
  assign wa     = req_addr[ADDR_W+1:2];
  assign wm     = {4'b0000, byte_mask(req_size)} << off;
  assign lat_wm = {4'b0000, byte_mask(size_q)} << off_q;
  assign hi_sh  = 6'd32 - {1'b0, off_q, 3'b000};
  assign cat    = {m_load_data, lo_q} >> {off_q, 3'b000};

  // Beat selection, split detection and response formation
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    off_d   = off_q;
    w_d     = w_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    rv_d    = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    ready_c = 1'b0;
    ce_c    = 1'b0;
    wr_c    = 1'b0;
    mask_c  = 4'b0000;
    addr_c  = '0;
    sdata_c = '0;
    unique case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (req_valid) begin
          if (req_size == 2'b11) begin
            rv_d    = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            ce_c    = 1'b1;
            wr_c    = req_we;
            addr_c  = wa;
            mask_c  = wm[3:0];
            sdata_c = req_wdata << {off, 3'b000};
            if (wm[7:4] == 4'b0000) begin
              rv_d    = 1'b1;
              rdata_d = req_we ? '0
                      : ext(m_load_data >> {off, 3'b000},
                            req_size, req_unsigned);
            end else begin
              lo_d    = m_load_data;
              size_d  = req_size;
              uns_d   = req_unsigned;
              we_d    = req_we;
              off_d   = off;
              w_d     = wa;
              wdata_d = req_wdata;
              state_d = SPLIT;
            end
          end
        end
      end
      SPLIT: begin
        ce_c    = 1'b1;
        wr_c    = we_q;
        addr_c  = w_q + 1'b1;
        mask_c  = lat_wm[7:4];
        sdata_c = wdata_q >> hi_sh;
        rv_d    = 1'b1;
        rdata_d = we_q ? '0 : ext(cat[DWIDTH-1:0], size_q, uns_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered response
  always_ff @(posedge m_clk or negedge m_rst) begin
    if (!m_rst) begin
      state_q <= IDLE;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      off_q   <= '0;
      w_q     <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      off_q   <= off_d;
      w_q     <= w_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready    = ready_c;
  assign resp_valid   = rv_q;
  assign resp_err     = err_q;
  assign resp_rdata   = rdata_q;
  assign m_ce         = m_rst & ce_c;
  assign m_wr_en      = m_rst & wr_c;
  assign m_mask       = m_rst ? mask_c : 4'b0000;
  assign m_addr       = m_rst ? addr_c : '0;
  assign m_store_data = m_rst ? sdata_c : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, reset-in-split sequence,
// and random traffic checked against a byte-array memory model.
module tb_mem_access_unit;

  logic        m_clk;
  logic        m_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        m_ce;
  logic        m_wr_en;
  logic [3:0]  m_mask;
  logic [7:0]  m_addr;
  logic [31:0] m_store_data;
  logic [31:0] m_load_data;

  mem_access_unit #(.ADDR_W(8), .DWIDTH(32)) dut (
    .m_clk(m_clk), .m_rst(m_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_ce(m_ce), .m_wr_en(m_wr_en), .m_mask(m_mask),
    .m_addr(m_addr), .m_store_data(m_store_data),
    .m_load_data(m_load_data)
  );

  initial m_clk = 1'b0;
  always #5 m_clk = ~m_clk;

  logic [31:0] mem [256] = '{default: 32'h0};
  logic [7:0]  ref_mem [1024];

  assign m_load_data = mem[m_addr];

  always @(negedge m_clk) begin
    if (m_ce && m_wr_en) begin
      for (int k = 0; k < 4; k++)
        if (m_mask[k]) mem[m_addr][8*k +: 8] <= m_store_data[8*k +: 8];
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ce0;
    logic [7:0]  addr0;
    logic [3:0]  mask0;
    logic [31:0] data0;
    logic        split;
    logic [7:0]  addr1;
    logic [3:0]  mask1;
    logic [31:0] data1;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic int bidx(input logic [31:0] a, input int k);
    return (int'(a[9:0]) + k) % 1024;
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] a,
                                        input logic [1:0] s,
                                        input logic u);
    int n;
    logic [31:0] v;
    n = nbytes(s);
    v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[bidx(a, k)];
    if (!u && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!u && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic mstore(input logic [31:0] a, input logic [1:0] s,
                        input logic [31:0] d);
    for (int k = 0; k < nbytes(s); k++) ref_mem[bidx(a, k)] = d[8*k +: 8];
  endtask

  // Issue one request at posedge+1 and check beats and the response.
  task automatic apply(input vec_t v, input bit beats, input string nm);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    #2;
    if (beats) begin
      chk({nm, " ce0"},   m_ce,         v.ce0);
      chk({nm, " addr0"}, m_addr,       v.addr0);
      chk({nm, " mask0"}, m_mask,       v.mask0);
      chk({nm, " data0"}, m_store_data, v.data0);
    end
    @(posedge m_clk);
    #1;
    req_valid = 1'b0;
    if (v.size != 2'b11 && v.we) mstore(v.addr, v.size, v.wdata);
    if (v.split) begin
      chk({nm, " ready_split"}, req_ready,  1'b0);
      chk({nm, " rv_early"},    resp_valid, 1'b0);
      if (beats) begin
        chk({nm, " addr1"}, m_addr,       v.addr1);
        chk({nm, " mask1"}, m_mask,       v.mask1);
        chk({nm, " data1"}, m_store_data, v.data1);
      end
      @(posedge m_clk);
      #1;
    end
    chk({nm, " rv"},    resp_valid, 1'b1);
    chk({nm, " err"},   resp_err,   v.err);
    chk({nm, " rdata"}, resp_rdata, v.rdata);
    chk({nm, " ready"}, req_ready,  1'b1);
  endtask

  vec_t tab [14];
  vec_t r;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    tab[0]  = '{1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 1'b1, 8'h04, 4'hF,
                32'hDEADBEEF, 1'b0, 8'h00, 4'h0, 32'h0, 32'h0, 1'b0};
    tab[1]  = '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 1'b1, 8'h04, 4'hF,
                32'h0, 1'b0, 8'h00, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0};
    tab[2]  = '{1'b1, 2'd0, 1'b0, 32'h013, 32'h80, 1'b1, 8'h04, 4'h8,
                32'h80000000, 1'b0, 8'h00, 4'h0, 32'h0, 32'h0, 1'b0};
    tab[3]  = '{1'b0, 2'd0, 1'b0, 32'h013, 32'h0, 1'b1, 8'h04, 4'h8,
                32'h0, 1'b0, 8'h00, 4'h0, 32'h0, 32'hFFFFFF80, 1'b0};
    tab[4]  = '{1'b0, 2'd0, 1'b1, 32'h013, 32'h0, 1'b1, 8'h04, 4'h8,
                32'h0, 1'b0, 8'h00, 4'h0, 32'h0, 32'h00000080, 1'b0};
    tab[5]  = '{1'b1, 2'd2, 1'b0, 32'h00C, 32'h44332211, 1'b1, 8'h03, 4'hF,
                32'h44332211, 1'b0, 8'h00, 4'h0, 32'h0, 32'h0, 1'b0};
    tab[6]  = '{1'b1, 2'd2, 1'b0, 32'h010, 32'h88776655, 1'b1, 8'h04, 4'hF,
                32'h88776655, 1'b0, 8'h00, 4'h0, 32'h0, 32'h0, 1'b0};
    tab[7]  = '{1'b0, 2'd2, 1'b0, 32'h00E, 32'h0, 1'b1, 8'h03, 4'hC,
                32'h0, 1'b1, 8'h04, 4'h3, 32'h0, 32'h66554433, 1'b0};
    tab[8]  = '{1'b1, 2'd1, 1'b0, 32'h007, 32'hABCD, 1'b1, 8'h01, 4'h8,
                32'hCD000000, 1'b1, 8'h02, 4'h1, 32'hAB, 32'h0, 1'b0};
    tab[9]  = '{1'b0, 2'd1, 1'b0, 32'h007, 32'h0, 1'b1, 8'h01, 4'h8,
                32'h0, 1'b1, 8'h02, 4'h1, 32'h0, 32'hFFFFABCD, 1'b0};
    tab[10] = '{1'b0, 2'd1, 1'b1, 32'h007, 32'h0, 1'b1, 8'h01, 4'h8,
                32'h0, 1'b1, 8'h02, 4'h1, 32'h0, 32'h0000ABCD, 1'b0};
    tab[11] = '{1'b0, 2'd3, 1'b0, 32'h020, 32'h0, 1'b0, 8'h00, 4'h0,
                32'h0, 1'b0, 8'h00, 4'h0, 32'h0, 32'h0, 1'b1};
    tab[12] = '{1'b1, 2'd2, 1'b0, 32'h3FE, 32'h12345678, 1'b1, 8'hFF, 4'hC,
                32'h56780000, 1'b1, 8'h00, 4'h3, 32'h1234, 32'h0, 1'b0};
    tab[13] = '{1'b0, 2'd2, 1'b0, 32'h3FE, 32'h0, 1'b1, 8'hFF, 4'hC,
                32'h0, 1'b1, 8'h00, 4'h3, 32'h0, 32'h12345678, 1'b0};

    m_rst        = 1'b0;
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = 32'h10;
    req_wdata    = 32'hFFFFFFFF;
    @(posedge m_clk);
    #1;
    chk("rst ready", req_ready,  1'b1);
    chk("rst rv",    resp_valid, 1'b0);
    chk("rst rdata", resp_rdata, 32'h0);
    chk("rst err",   resp_err,   1'b0);
    chk("rst ce",    m_ce,       1'b0);
    chk("rst wr",    m_wr_en,    1'b0);
    chk("rst mask",  m_mask,     4'h0);
    chk("rst sdata", m_store_data, 32'h0);
    req_valid = 1'b0;
    m_rst     = 1'b1;
    @(posedge m_clk);
    #1;

    for (int i = 0; i < 14; i++) apply(tab[i], 1'b1, $sformatf("dir%0d", i));

    // Reset during the second beat of a split store
    r = '{1'b1, 2'd2, 1'b0, 32'h034, 32'hCAFEF00D, 1'b1, 8'h0D, 4'hF,
          32'hCAFEF00D, 1'b0, 8'h00, 4'h0, 32'h0, 32'h0, 1'b0};
    apply(r, 1'b1, "pre");
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h032;
    req_wdata = 32'h11223344;
    @(posedge m_clk);
    #1;
    req_valid = 1'b0;
    chk("ab ready_split", req_ready, 1'b0);
    chk("ab ce_split",    m_ce,      1'b1);
    #1;
    m_rst = 1'b0;
    #1;
    chk("ab ce",    m_ce,         1'b0);
    chk("ab wr",    m_wr_en,      1'b0);
    chk("ab mask",  m_mask,       4'h0);
    chk("ab addr",  m_addr,       8'h0);
    chk("ab sdata", m_store_data, 32'h0);
    chk("ab ready", req_ready,    1'b1);
    @(negedge m_clk);
    #2;
    m_rst = 1'b1;
    @(posedge m_clk);
    #1;
    chk("ab rv1", resp_valid, 1'b0);
    @(posedge m_clk);
    #1;
    chk("ab rv2",   resp_valid, 1'b0);
    chk("ab hi",    mem[13],    32'hCAFEF00D);
    chk("ab lo",    {16'h0, mem[12][31:16]}, 32'h3344);
    chk("ab ready2", req_ready, 1'b1);
    ref_mem[12'h032] = 8'h44;
    ref_mem[12'h033] = 8'h33;

    for (int i = 0; i < 200; i++) begin
      logic [9:0] base;
      int n;
      base    = ($urandom_range(0, 3) == 0) ? 10'h3F8 : 10'h040;
      r.we    = 1'($urandom_range(0, 1));
      r.size  = ($urandom_range(0, 9) == 0) ? 2'd3
                                            : 2'($urandom_range(0, 2));
      r.uns   = 1'($urandom_range(0, 1));
      r.addr  = {$urandom() >> 10, 10'h0} | 32'(base + 10'($urandom_range(0, 15)));
      r.addr[31:10] = 22'($urandom());
      r.wdata = $urandom();
      r.err   = (r.size == 2'd3);
      n       = nbytes(r.size);
      r.split = !r.err && (int'(r.addr[1:0]) + n > 4);
      r.rdata = (r.err || r.we) ? 32'h0 : mload(r.addr, r.size, r.uns);
      apply(r, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store initiator that drives the data memory's word-addressed, byte-masked port (ce, wr_en, 4-bit mask, word address, store data, combinational load data).
- Converts pipeline byte-address requests (byte/half/word, signed/unsigned) into lane-aligned memory beats.
- Splits accesses that cross a word boundary into two beats and stalls the pipeline for that beat.
- Merges, shifts and sign/zero-extends returned load data.

Parameters:
- ADDR_W, 8: word-address width of the memory port; byte address bits [ADDR_W+1:2] form the word index.
- DWIDTH, 32: data width; fixed at 32, i.e. 4 byte lanes.

Ports:
- m_clk  input  1  clock; the memory commits writes on the falling edge.
- m_rst  input  1  reset, asynchronous, active-low.
- req_valid  input  1  access request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  zero-extend the load (lbu/lhu).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse, for loads and stores.
- resp_rdata  output  32  extended load data; 0 for stores.
- resp_err  output  1  reserved size; qualified by resp_valid.
- m_ce  output  1  memory chip enable.
- m_wr_en  output  1  memory write enable.
- m_mask  output  4  byte-lane mask; bit k selects lane k, bits [8k+7:8k].
- m_addr  output  ADDR_W  word address.
- m_store_data  output  32  lane-aligned store data.
- m_load_data  input  32  combinational read data from memory.

Behaviour:
- FSM states: IDLE and SPLIT.
  - Reset → IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - All m_* outputs are forced to 0 while m_rst is low.
- Decode: o = req_addr[1:0]; w = req_addr[ADDR_W+1:2]; n = 1, 2 or 4 bytes; bm = 0001, 0011 or 1111; wide mask M = bm << o (8 bits).
- Little-endian: request byte k maps to lane (o+k) mod 4.
- IDLE with req_valid=1 drives beat 0 combinationally in the same cycle:
  - m_ce=1, m_wr_en=req_we, m_addr=w, m_mask=M[3:0], m_store_data=(req_wdata<<8o)[31:0].
  - The request is accepted at the rising edge.
- Single-beat case (M[7:4]==0): at the accepting edge, register the response. resp_valid is 1 in cycle T+1.
- Split case (M[7:4]!=0), at the accepting edge:
  - latch m_load_data as lo, and latch size, unsigned, we, o, w and wdata;
  - go to SPLIT.
- SPLIT state (cycle T+1):
  - req_ready=0; beat 1 is driven from the latched values;
  - m_addr=w+1, wrapping mod 2^ADDR_W; m_mask=M[7:4]; m_store_data=req_wdata>>8(4-o).
  - At the next edge, register the response (resp_valid in T+2) and return to IDLE.
- req_ready=1 in IDLE. Back-to-back single-beat requests complete one per cycle.
- Load result:
  - Single beat: raw = m_load_data>>8o. Split: raw = ({m_load_data, lo}>>8o)[31:0].
  - Keep the low n bytes. Sign-extend from bit 8n-1 unless req_unsigned=1 or n=4.
- Stores: resp_rdata=0. Each memory write happens on the negedge inside its beat cycle.
- Reserved size (11): m_ce=0, no memory access; resp_valid pulses in T+1 with resp_err=1 and resp_rdata=0.
- resp_valid and resp_err clear to 0 in the cycle after the pulse unless a new response is pending.
- Reset asserted in SPLIT:
  - immediate return to IDLE and m_* forced to 0, so beat 1 is never issued;
  - no resp_valid is generated for the aborted request; beat-0 writes already committed are retained.
- Registers: none beyond the state, the latched request, lo and the response registers. No combinational path from m_load_data to resp_*.

Test Plan:
- sw 0xDEADBEEF @0x10, then lw @0x10 → beat m_addr=4, mask 1111, data 0xDEADBEEF; load resp_rdata=0xDEADBEEF in T+1, req_ready stays 1.
- sb 0x80 @0x13 → mask 1000, m_store_data 0x80000000. Then lb @0x13 → 0xFFFFFF80; lbu @0x13 → 0x00000080.
- Preload word3=0x44332211, word4=0x88776655; lw @0x0E:
  - beat0 addr 3, mask 1100; beat1 addr 4, mask 0011; req_ready=0 for one cycle;
  - resp_rdata=0x66554433 in T+2.
- sh 0xABCD @0x07:
  - beat0 addr 1, mask 1000, data 0xCD000000; beat1 addr 2, mask 0001, data 0x000000AB;
  - lh @0x07 → 0xFFFFABCD; lhu @0x07 → 0x0000ABCD.
- Wrap-around: lw @byte 0x3FE (ADDR_W=8) → beat0 addr 0xFF, beat1 addr 0x00. Reserved size → m_ce=0, resp_err=1, resp_rdata=0.
- Assert m_rst during SPLIT of a split store → m_* go to 0 immediately; no resp_valid; the beat-1 word is unchanged; after release req_ready=1 in IDLE.
